mouse_analog_emu: RTL and testbench

- Multi-port mouse-to-analog-stick emulator for console cores such as the 5200 top level.
- Integrates PS/2 mouse deltas from hps_io into signed saturating X/Y positions on a selectable controller port.
- Substitutes mouse buttons into that port's digital fire bits.
- Generalises the single-port inline emulator with a port count, axis width, delta clamp, sensitivity shift, port routing and optional spring-return recentre.

---
 rtl/mouse_analog_emu.sv | 162 ++++++++++++++++
 tb/tb_mouse_analog_emu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_analog_emu.sv
// Mouse-to-analog-stick emulator: integrates PS/2 mouse deltas into signed,
// saturating X/Y axes on one selectable controller port. The mouse buttons
// replace that port's fire bits [5:4]. Optional spring-return recentring.
module mouse_analog_emu #(
    parameter int NUM_PORTS   = 2,
    parameter int AXIS_W      = 8,
    parameter int DELTA_MAX   = 10,
    parameter int RC_DIV_LOG2 = 16,
    parameter int PSEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          i_clk_sys,
    input  logic                          i_reset,
    input  logic [24:0]                   i_ps2_mouse,
    input  logic [1:0]                    i_sens,
    input  logic [PSEL_W-1:0]             i_port_sel,
    input  logic                          i_recenter_en,
    input  logic                          i_cpu_halt,
    input  logic [NUM_PORTS*16-1:0]       i_joya,
    input  logic [NUM_PORTS*16-1:0]       i_joy,
    output logic [NUM_PORTS*AXIS_W-1:0]   o_ax_out,
    output logic [NUM_PORTS*AXIS_W-1:0]   o_ay_out,
    output logic [NUM_PORTS*16-1:0]       o_joy_out,
    output logic [NUM_PORTS-1:0]          o_emu_act
);

    localparam logic signed [AXIS_W-1:0]   A_MAX = {1'b0, {(AXIS_W-1){1'b1}}};
    localparam logic signed [AXIS_W-1:0]   A_MIN = {1'b1, {(AXIS_W-1){1'b0}}};
    localparam logic signed [AXIS_W-1:0]   A_ONE = AXIS_W'(1);
    localparam logic signed [AXIS_W+1:0]   N_MAX = (AXIS_W+2)'(A_MAX);
    localparam logic signed [AXIS_W+1:0]   N_MIN = (AXIS_W+2)'(A_MIN);

    logic signed [AXIS_W-1:0]  r_acc_x [NUM_PORTS];
    logic signed [AXIS_W-1:0]  r_acc_y [NUM_PORTS];
    logic [NUM_PORTS-1:0]      r_emu;
    logic                      r_stb_q;
    logic                      r_primed;
    logic [PSEL_W-1:0]         r_psel_q;
    logic [RC_DIV_LOG2-1:0]    r_prescaler;

    logic                      w_event;
    logic                      w_switch;
    logic                      w_tick;
    logic [NUM_PORTS-1:0]      w_ovr;
    logic signed [AXIS_W+1:0]  w_dx;
    logic signed [AXIS_W+1:0]  w_dy;
    logic                      w_unused_ps2;

    // Sign-extend the 9-bit delta, apply sensitivity shift, clamp magnitude.
    function automatic logic signed [AXIS_W+1:0] f_delta(input logic sgn,
                                                         input logic [7:0] raw,
                                                         input logic [1:0] sh);
        logic signed [8:0] d;
        int v;
        d = {sgn, raw};
        v = int'(d >>> sh);
        if (v > DELTA_MAX)
            v = DELTA_MAX;
        else if (v < -DELTA_MAX)
            v = -DELTA_MAX;
        return (AXIS_W+2)'(v);
    endfunction

    // Two guard bits keep acc + delta exact before saturating to AXIS_W.
    function automatic logic signed [AXIS_W-1:0] f_add_sat(input logic signed [AXIS_W-1:0] acc,
                                                           input logic signed [AXIS_W+1:0] dc);
        logic signed [AXIS_W+1:0] n;
        n = (AXIS_W+2)'(acc) + dc;
        if (n > N_MAX)
            return A_MAX;
        else if (n < N_MIN)
            return A_MIN;
        else
            return AXIS_W'(n);
    endfunction

    // One LSB toward zero; zero stays zero.
    function automatic logic signed [AXIS_W-1:0] f_step(input logic signed [AXIS_W-1:0] acc);
        if (acc == '0)
            return acc;
        else if (acc[AXIS_W-1])
            return acc + A_ONE;
        else
            return acc - A_ONE;
    endfunction

    // Native 8-bit analog value sign-extended or truncated to the axis width.
    function automatic logic [AXIS_W-1:0] f_pass(input logic [7:0] v);
        int sv;
        sv = int'(signed'(v));
        return AXIS_W'(sv);
    endfunction

    assign w_event      = r_primed && (r_stb_q != i_ps2_mouse[24]);
    assign w_switch     = (i_port_sel != r_psel_q);
    assign w_tick       = &r_prescaler;
    assign w_dx         = f_delta(i_ps2_mouse[4], i_ps2_mouse[15:8],  i_sens);
    assign w_dy         = f_delta(i_ps2_mouse[5], i_ps2_mouse[23:16], i_sens);
    assign w_unused_ps2 = ^{i_ps2_mouse[7:6], i_ps2_mouse[3:2]};

    // Per-port override: native stick deflected or CPU halted.
    always_comb begin
        w_ovr = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            w_ovr[p] = i_cpu_halt || (i_joya[p*16 +: 16] != 16'h0000);
    end

    // Strobe edge detect, port tracking, prescaler and per-port accumulators.
    always_ff @(posedge i_clk_sys or posedge i_reset) begin
        if (i_reset) begin
            r_stb_q     <= 1'b0;
            r_primed    <= 1'b0;
            r_psel_q    <= '0;
            r_prescaler <= '0;
            r_emu       <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                r_acc_x[p] <= '0;
                r_acc_y[p] <= '0;
            end
        end else begin
            r_stb_q     <= i_ps2_mouse[24];
            r_primed    <= 1'b1;
            r_psel_q    <= i_port_sel;
            r_prescaler <= r_prescaler + 1'b1;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_ovr[p] || w_switch) begin
                    r_emu[p]   <= 1'b0;
                    r_acc_x[p] <= '0;
                    r_acc_y[p] <= '0;
                end else if (w_event && (r_psel_q == PSEL_W'(p))) begin
                    r_emu[p]   <= 1'b1;
                    r_acc_x[p] <= f_add_sat(r_acc_x[p], w_dx);
                    r_acc_y[p] <= f_add_sat(r_acc_y[p], w_dy);
                end else if (w_tick && i_recenter_en && !w_event && r_emu[p]) begin
                    r_acc_x[p] <= f_step(r_acc_x[p]);
                    r_acc_y[p] <= f_step(r_acc_y[p]);
                end
            end
        end
    end

    // Output mux: emulated axes and mouse buttons on active ports, else native.
    always_comb begin
        o_ax_out  = '0;
        o_ay_out  = '0;
        o_joy_out = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (r_emu[p]) begin
                o_ax_out[p*AXIS_W +: AXIS_W] = r_acc_x[p];
                o_ay_out[p*AXIS_W +: AXIS_W] = r_acc_y[p];
                o_joy_out[p*16 +: 16]        = {i_joy[p*16+6 +: 10], i_ps2_mouse[1:0],
                                                i_joy[p*16 +: 4]};
            end else begin
                o_ax_out[p*AXIS_W +: AXIS_W] = f_pass(i_joya[p*16 +: 8]);
                o_ay_out[p*AXIS_W +: AXIS_W] = f_pass(i_joya[p*16+8 +: 8]);
                o_joy_out[p*16 +: 16]        = i_joy[p*16 +: 16];
            end
        end
    end

    assign o_emu_act = r_emu;

endmodule

// File: tb/tb_mouse_analog_emu.sv
// Scoreboard bench for mouse_analog_emu (2 ports, 8-bit axes, fast recentre).
module tb_mouse_analog_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] ps2;
    logic [1:0]  sens;
    logic [0:0]  port_sel;
    logic        rc_en;
    logic        halt;
    logic [31:0] joya;
    logic [31:0] joy;
    logic [15:0] ax_out;
    logic [15:0] ay_out;
    logic [31:0] joy_out;
    logic [1:0]  emu_act;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mouse_analog_emu #(
        .NUM_PORTS  (2),
        .AXIS_W     (8),
        .DELTA_MAX  (10),
        .RC_DIV_LOG2(4)
    ) dut (
        .i_clk_sys    (clk),
        .i_reset      (rst),
        .i_ps2_mouse  (ps2),
        .i_sens       (sens),
        .i_port_sel   (port_sel),
        .i_recenter_en(rc_en),
        .i_cpu_halt   (halt),
        .i_joya       (joya),
        .i_joy        (joy),
        .o_ax_out     (ax_out),
        .o_ay_out     (ay_out),
        .o_joy_out    (joy_out),
        .o_emu_act    (emu_act)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // 0/1: ax port0/1, 2/3: ay port0/1, 4: emu_act, 5/6: joy_out port0/1
    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0:       return {24'h0, ax_out[7:0]};
            1:       return {24'h0, ax_out[15:8]};
            2:       return {24'h0, ay_out[7:0]};
            3:       return {24'h0, ay_out[15:8]};
            4:       return {30'h0, emu_act};
            5:       return {16'h0, joy_out[15:0]};
            default: return {16'h0, joy_out[31:16]};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        if (sel < 4)
            e.exp = {24'h0, 8'(val)};
        else if (sel == 4)
            e.exp = {30'h0, 2'(val)};
        else
            e.exp = {16'h0, 16'(val)};
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Toggle the strobe with new delta/button fields; outputs valid after one edge.
    task automatic send(input logic sx, input logic [7:0] rx, input logic sy,
                        input logic [7:0] ry, input logic [1:0] btn);
        ps2[24]    = ~ps2[24];
        ps2[4]     = sx;
        ps2[5]     = sy;
        ps2[15:8]  = rx;
        ps2[23:16] = ry;
        ps2[1:0]   = btn;
        step();
    endtask

    function automatic int jexp(input logic [15:0] j, input logic [1:0] btn);
        return int'((j & 16'hFFCF) | (16'(btn) << 4));
    endfunction

    initial begin
        rst      = 1'b1;
        ps2      = 25'h1000000;
        sens     = 2'd1;
        port_sel = 1'b0;
        rc_en    = 1'b0;
        halt     = 1'b0;
        joya     = 32'h9F20_0000;
        joy      = 32'hA5C3_3C5A;
        #1;

        // Reset state: pass-through everywhere
        push("rst_ax0", 0, 0);
        push("rst_ay0", 2, 0);
        push("rst_ax1", 1, 8'h20);
        push("rst_ay1", 3, 8'h9F);
        push("rst_emu", 4, 0);
        push("rst_joy0", 5, 16'h3C5A);
        push("rst_joy1", 6, 16'hA5C3);
        drain();

        // Strobe held high through reset release must not count as an event
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        step();
        push("prime_emu", 4, 0);
        push("prime_ax0", 0, 0);
        drain();

        // Legacy sensitivity: +20 >> 1 = 10
        send(1'b0, 8'h14, 1'b0, 8'h00, 2'b10);
        push("leg_ax0", 0, 10);
        push("leg_ay0", 2, 0);
        push("leg_emu", 4, 2'b01);
        push("leg_joy0", 5, jexp(16'h3C5A, 2'b10));
        push("leg_ax1", 1, 8'h20);
        push("leg_joy1", 6, 16'hA5C3);
        drain();
        step();
        push("leg_once_ax0", 0, 10);
        drain();

        // Halt clears; then clamp (64 -> 10) and saturate both ways
        halt = 1'b1;
        step();
        halt = 1'b0;
        push("halt_emu", 4, 0);
        push("halt_ax0", 0, 0);
        drain();
        sens = 2'd0;
        for (int i = 1; i <= 13; i++) begin
            send(1'b0, 8'h40, 1'b0, 8'h00, 2'b01);
            push($sformatf("clamp_up%0d", i), 0, (10 * i > 127) ? 127 : 10 * i);
            drain();
        end
        for (int i = 1; i <= 26; i++) begin
            send(1'b1, 8'hC0, 1'b0, 8'h00, 2'b01);
            push($sformatf("clamp_dn%0d", i), 0, (127 - 10 * i < -128) ? -128 : 127 - 10 * i);
            drain();
        end

        // Native deflection overrides a simultaneous event
        joya[15:0] = 16'h0040;
        send(1'b0, 8'h40, 1'b0, 8'h40, 2'b00);
        push("ovr_emu", 4, 0);
        push("ovr_ax0", 0, 8'h40);
        push("ovr_ay0", 2, 0);
        drain();
        joya[15:0] = 16'h0000;
        step();
        push("ovr_rel_ax0", 0, 0);
        drain();
        send(1'b0, 8'h14, 1'b0, 8'h00, 2'b00);
        push("reacq_ax0", 0, 10);
        push("reacq_emu", 4, 2'b01);
        drain();
        halt = 1'b1;
        send(1'b0, 8'h14, 1'b0, 8'h00, 2'b00);
        halt = 1'b0;
        push("haltev_emu", 4, 0);
        push("haltev_ax0", 0, 0);
        drain();

        // Port switch with simultaneous event: all cleared, event dropped
        joya = 32'h0000_0000;
        for (int i = 0; i < 3; i++)
            send(1'b0, 8'h40, 1'b0, 8'h00, 2'b11);
        push("sw_pre_ax0", 0, 30);
        drain();
        port_sel = 1'b1;
        send(1'b0, 8'h40, 1'b0, 8'h00, 2'b11);
        push("sw_emu", 4, 0);
        push("sw_ax0", 0, 0);
        push("sw_ax1", 1, 0);
        drain();
        send(1'b0, 8'h40, 1'b1, 8'hFB, 2'b11);
        push("p1_ax1", 1, 10);
        push("p1_ay1", 3, -5);
        push("p1_ax0", 0, 0);
        push("p1_emu", 4, 2'b10);
        push("p1_joy1", 6, jexp(16'hA5C3, 2'b11));
        push("p1_joy0", 5, 16'h3C5A);
        drain();
        port_sel = 1'b0;

        // Recentre: fresh reset so ticks land on edges 16, 32, 48, ...
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        step();
        rc_en = 1'b1;
        send(1'b0, 8'h05, 1'b1, 8'hFD, 2'b00);
        push("rc_ax0_init", 0, 5);
        push("rc_ay0_init", 2, -3);
        drain();
        while (cyc < 48) step();
        push("rc3_ay0", 2, 0);
        push("rc3_ax0", 0, 2);
        drain();
        while (cyc < 80) step();
        push("rc5_ax0", 0, 0);
        push("rc5_ay0", 2, 0);
        push("rc5_emu", 4, 2'b01);
        drain();
        while (cyc < 112) step();
        push("rc7_ax0", 0, 0);
        push("rc7_emu", 4, 2'b01);
        drain();
        rc_en = 1'b0;
        send(1'b0, 8'h07, 1'b0, 8'h00, 2'b00);
        push("hold_ax0_set", 0, 7);
        drain();
        while (cyc < 200) step();
        push("hold_ax0", 0, 7);
        push("hold_emu", 4, 2'b01);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
